receiving_device: RTL and testbench

RECEIVING_DEVICE -- requirements
Module: receiving_device

---
 rtl/receiving_device_pkg.sv | 38 +++
 rtl/receiving_device_rx_fifo.sv | 54 +++++
 rtl/receiving_device.sv | 223 ++++++++++++++++++++++
 tb/tb_receiving_device.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/receiving_device_pkg.sv
// Shared definitions for the serial receiver: default word size, receiver
// state encoding and the active-low seven-segment digit table.
// The PARITY state exists only when RECEIVING_DEVICE_PARITY_EN is defined.
package receiving_device_pkg;

  localparam int unsigned WORD_SIZE_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef RECEIVING_DEVICE_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_t;

  // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment; index = digit value.
  localparam logic [0:15][6:0] SEG_TABLE = {
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000, // 9
    7'b0001000, // A
    7'b0000011, // b
    7'b1000110, // C
    7'b0100001, // d
    7'b0000110, // E
    7'b0001110  // F
  };

endpackage

// File: rtl/receiving_device_rx_fifo.sv
// Word FIFO for received frames. Pointers carry one extra wrap bit so full and
// empty come straight from registered pointer compares.
module rx_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  // Pop needs data present; push needs space, or a pop in the same cycle.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    wr_d    = wr_q + {{AW{1'b0}}, push_ok};
    rd_d    = rd_q + {{AW{1'b0}}, pop_ok};
    dout    = mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/receiving_device.sv
// Serial frame receiver: synchronizes rx, decodes start/data/[parity]/stop
// frames into a FIFO, pops words to data_out on read_req and drives a
// seven-segment image of the last popped word.
// Optional even parity bit: define RECEIVING_DEVICE_PARITY_EN.
module receiving_device
  import receiving_device_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEFAULT,
  parameter int unsigned BIT_PERIOD = 10,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 read_req,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic [6:0]           hex,
  output logic                 full,
  output logic                 empty,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 parity_error
);

  localparam int unsigned    TW        = $clog2(BIT_PERIOD);
  localparam int unsigned    CW        = $clog2(WORD_SIZE + 1);
  localparam logic [TW-1:0]  HALF_LAST = TW'(BIT_PERIOD / 2 - 1);
  localparam logic [TW-1:0]  FULL_LAST = TW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0]  LAST_BIT  = CW'(WORD_SIZE - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [1:0]           sync_ok_q, sync_ok_d;
  logic                 rx_prev_q, rx_prev_d;
  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_SIZE-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [WORD_SIZE-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
`ifdef RECEIVING_DEVICE_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  logic                 parity_set;
`endif

  logic                 rx_s;
  logic                 fall;
  logic                 push;
  logic                 frame_err_set;
  logic                 pop_ok;
  logic [WORD_SIZE-1:0] fifo_dout;
  logic [3:0]           digit;

  // Synchronizer and edge detect. rx_prev only loads once sync2 holds a real
  // rx sample, so the reset-value 1 of the synchronizer never fakes an edge
  // when the line is already low at reset release.
  always_comb begin
    sync1_d   = rx;
    sync2_d   = sync1_q;
    sync_ok_d = {sync_ok_q[0], 1'b1};
    rx_s      = sync2_q;
    rx_prev_d = sync_ok_q[1] & rx_s;
    fall      = rx_prev_q & ~rx_s;
  end

  // Frame decoder next-state logic.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + 1'b1;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
`ifdef RECEIVING_DEVICE_PARITY_EN
    par_bad_d     = par_bad_q;
    parity_set    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (fall) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
`ifdef RECEIVING_DEVICE_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_DATA: begin
        if (timer_q == FULL_LAST) begin
          timer_d                = '0;
          shift_d                = shift_q >> 1;
          shift_d[WORD_SIZE-1]   = rx_s;
          bit_cnt_d              = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef RECEIVING_DEVICE_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef RECEIVING_DEVICE_PARITY_EN
      ST_PARITY: begin
        if (timer_q == FULL_LAST) begin
          timer_d    = '0;
          par_bad_d  = (^shift_q) ^ rx_s;
          parity_set = par_bad_d;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (timer_q == FULL_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
          if (!rx_s) begin
            frame_err_set = 1'b1;
          end else begin
`ifdef RECEIVING_DEVICE_PARITY_EN
            push = ~par_bad_q;
`else
            push = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Read side, sticky flags and display decode.
  always_comb begin
    pop_ok       = read_req & ~empty;
    data_out_d   = pop_ok ? fifo_dout : data_out_q;
    data_valid_d = pop_ok;
    frame_err_d  = frame_err_q | frame_err_set;
    overrun_d    = overrun_q | (push & full & ~pop_ok);
`ifdef RECEIVING_DEVICE_PARITY_EN
    parity_err_d = parity_err_q | parity_set;
`endif
    digit        = 4'(data_out_q);
    hex          = SEG_TABLE[digit];
  end

  // State registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      sync_ok_q    <= '0;
      rx_prev_q    <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
`ifdef RECEIVING_DEVICE_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      sync_ok_q    <= sync_ok_d;
      rx_prev_q    <= rx_prev_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
`ifdef RECEIVING_DEVICE_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  rx_fifo #(
    .WIDTH(WORD_SIZE),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(CLOCK_50),
    .reset(reset),
    .push (push),
    .pop  (read_req),
    .din  (shift_q),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_err_q;
  assign overrun     = overrun_q;
`ifdef RECEIVING_DEVICE_PARITY_EN
  assign parity_error = parity_err_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_receiving_device.sv
// Self-checking bench for receiving_device: table of frames plus hand-written
// sequences for glitch, overrun, mid-frame reset and (optionally) parity.
module tb_receiving_device;

  localparam int W  = 4;
  localparam int BP = 10;
  localparam int D  = 8;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         rx;
  logic         read_req;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic [6:0]   hex;
  logic         full;
  logic         empty;
  logic         frame_error;
  logic         overrun;
  logic         parity_error;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  logic [3:0] last_word;

  typedef struct {
    logic [3:0] data;
    logic       stop;
    logic       exp_store;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[5];

  receiving_device #(
    .WORD_SIZE (W),
    .BIT_PERIOD(BP),
    .DEPTH     (D)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rx          (rx),
    .read_req    (read_req),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .hex         (hex),
    .full        (full),
    .empty       (empty),
    .frame_error (frame_error),
    .overrun     (overrun),
    .parity_error(parity_error)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required $finish before time limit");
    $fatal(1);
  end

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
    endcase
  endfunction

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk_n(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk_h(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BP) @(negedge CLOCK_50);
  endtask

`ifdef RECEIVING_DEVICE_PARITY_EN
  task automatic send_frame_p(input logic [3:0] d, input logic stop, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    rx = 1'b1;
    idle(5);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop);
    send_frame_p(d, stop, ^d);
  endtask
`else
  task automatic send_frame(input logic [3:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
    idle(5);
  endtask
`endif

  // Pop one word and compare against the scoreboard head.
  task automatic do_read();
    logic [3:0] e;
    read_req = 1'b1;
    @(negedge CLOCK_50);
    read_req = 1'b0;
    e = sb.pop_front();
    chk_n("data_out", data_out, e);
    chk_b("data_valid", data_valid, 1'b1);
    chk_h("hex", hex, seg(e));
    last_word = e;
    @(negedge CLOCK_50);
    chk_b("data_valid_one_cycle", data_valid, 1'b0);
  endtask

  task automatic drain();
    while (sb.size() > 0) do_read();
    chk_b("empty_after_drain", empty, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    chk_n({tag, "_data_out"}, data_out, 4'h0);
    chk_b({tag, "_data_valid"}, data_valid, 1'b0);
    chk_h({tag, "_hex"}, hex, seg(4'h0));
    chk_b({tag, "_empty"}, empty, 1'b1);
    chk_b({tag, "_full"}, full, 1'b0);
    chk_b({tag, "_frame_error"}, frame_error, 1'b0);
    chk_b({tag, "_overrun"}, overrun, 1'b0);
    chk_b({tag, "_parity_error"}, parity_error, 1'b0);
  endtask

  initial begin
    tbl[0] = '{data: 4'hA, stop: 1'b1, exp_store: 1'b1, exp_ferr: 1'b0};
    tbl[1] = '{data: 4'h5, stop: 1'b0, exp_store: 1'b0, exp_ferr: 1'b1};
    tbl[2] = '{data: 4'h3, stop: 1'b1, exp_store: 1'b1, exp_ferr: 1'b1};
    tbl[3] = '{data: 4'hF, stop: 1'b1, exp_store: 1'b1, exp_ferr: 1'b1};
    tbl[4] = '{data: 4'h0, stop: 1'b1, exp_store: 1'b1, exp_ferr: 1'b1};

    rx        = 1'b1;
    read_req  = 1'b0;
    reset     = 1'b1;
    last_word = 4'h0;
    idle(3);
    reset = 1'b0;
    idle(5);
    check_reset_values("reset");

    // Short low pulse on an idle line is a glitch, not a start bit.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    chk_b("glitch_empty", empty, 1'b1);
    chk_b("glitch_frame_error", frame_error, 1'b0);

    // Frame table: each entry sent, flags checked, then drained.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].stop);
      if (tbl[i].exp_store) sb.push_back(tbl[i].data);
      chk_b("tbl_frame_error", frame_error, tbl[i].exp_ferr);
      chk_b("tbl_empty", empty, ~tbl[i].exp_store);
      drain();
    end

    // Read on empty FIFO is ignored.
    read_req = 1'b1;
    @(negedge CLOCK_50);
    read_req = 1'b0;
    chk_b("empty_read_valid", data_valid, 1'b0);
    chk_n("empty_read_hold", data_out, last_word);

    // Fill past capacity without reading.
    for (int i = 0; i < 9; i++) begin
      send_frame(4'(i), 1'b1);
      if (i < D) sb.push_back(4'(i));
      if (i == D - 1) begin
        chk_b("fill_full", full, 1'b1);
        chk_b("fill_no_overrun_yet", overrun, 1'b0);
      end
    end
    chk_b("overflow_full", full, 1'b1);
    chk_b("overflow_overrun", overrun, 1'b1);
    drain();
    chk_b("drained_full", full, 1'b0);
    chk_b("overrun_sticky", overrun, 1'b1);

    // Reset in the middle of a frame's data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    rx = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(2);
    check_reset_values("midframe_reset");
    reset = 1'b0;
    idle(30);
    rx = 1'b1;
    idle(80);
    chk_b("post_reset_no_bogus_frame", empty, 1'b1);
    send_frame(4'hC, 1'b1);
    sb.push_back(4'hC);
    chk_b("post_reset_stored", empty, 1'b0);
    drain();

`ifdef RECEIVING_DEVICE_PARITY_EN
    send_frame_p(4'h7, 1'b1, 1'b0);
    chk_b("parity_bad_flag", parity_error, 1'b1);
    chk_b("parity_bad_dropped", empty, 1'b1);
    send_frame_p(4'h7, 1'b1, 1'b1);
    sb.push_back(4'h7);
    chk_b("parity_good_stored", empty, 1'b0);
    drain();
    chk_b("parity_sticky", parity_error, 1'b1);
`else
    chk_b("parity_tied_low", parity_error, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
